// File: rtl/mips_cpu_pkg.sv
// Shared widths, register-zero constant and requester identifiers for the writeback path.
// Pure declarations: no logic, no latency, no flow control.
package mips_cpu_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_W;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

endpackage

// File: rtl/mips_cpu_wb_scoreboard.sv
// Register scoreboard: issue sets a busy bit, writeback clears it, decode looks up rs/rt.
// Set/clear take effect at the edge; hazard is combinational from pre-edge state; no backpressure.
module mips_cpu_wb_scoreboard
    import mips_cpu_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_arst_n,
    input  logic                 i_set_vld,
    input  logic [REG_W-1:0]     i_set_reg,
    input  logic                 i_clr_vld,
    input  logic [REG_W-1:0]     i_clr_reg,
    input  logic                 i_issue_vld,
    input  logic [REG_W-1:0]     i_rs,
    input  logic [REG_W-1:0]     i_rt,
    output logic [NUM_REGS-1:0]  o_pending,
    output logic                 o_hazard
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic                w_rs_busy;
    logic                w_rt_busy;

    // The set mask is OR-ed in after the clear so a same-edge issue keeps the register busy.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_vld && (i_set_reg != REG_ZERO)) begin
            w_set_mask[i_set_reg] = 1'b1;
        end
        if (i_clr_vld && (i_clr_reg != REG_ZERO)) begin
            w_clr_mask[i_clr_reg] = 1'b1;
        end
        w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    always_comb begin
        w_rs_busy = (i_rs != REG_ZERO) && r_pending[i_rs];
        w_rt_busy = (i_rt != REG_ZERO) && r_pending[i_rt];
        o_hazard  = i_issue_vld && (w_rs_busy || w_rt_busy);
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/mips_cpu_reg_wb_arbiter.sv
// Arbitrates ALU and load-return writebacks onto the single register-file write port.
// Ready is combinational, write strobe lands one cycle after the handshake; losers simply wait.
module mips_cpu_reg_wb_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int unsigned ALU_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    input  logic [REG_W-1:0]     alu_dest,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [REG_W-1:0]     mem_dest,
    input  logic [DATA_W-1:0]    mem_data,
    output logic                 mem_ready,
    input  logic                 issue_valid,
    input  logic [REG_W-1:0]     issue_dest,
    input  logic [REG_W-1:0]     rs,
    input  logic [REG_W-1:0]     rt,
    output logic                 rf_write_en,
    output logic [REG_W-1:0]     rf_a3,
    output logic [DATA_W-1:0]    rf_writedata,
    output logic [NUM_REGS-1:0]  pending,
    output logic                 hazard
);

    localparam req_e PRIO_RST = (ALU_FIRST != 0) ? REQ_ALU : REQ_MEM;

    req_e               r_prio;
    logic               r_rf_we;
    logic [REG_W-1:0]   r_rf_a3;
    logic [DATA_W-1:0]  r_rf_wd;

    logic               w_conflict;
    logic               w_alu_grant;
    logic               w_mem_grant;
    logic               w_grant_vld;
    logic [REG_W-1:0]   w_grant_dest;
    logic [DATA_W-1:0]  w_grant_data;

    always_comb begin
        w_conflict  = alu_valid && mem_valid;
        w_alu_grant = alu_valid && (!mem_valid || (r_prio == REQ_ALU));
        w_mem_grant = mem_valid && (!alu_valid || (r_prio == REQ_MEM));
        w_grant_vld = w_alu_grant || w_mem_grant;
    end

    always_comb begin
        w_grant_dest = mem_dest;
        w_grant_data = mem_data;
        if (w_alu_grant) begin
            w_grant_dest = alu_dest;
            w_grant_data = alu_data;
        end
    end

    // Pointer only moves on a real conflict, and always toward the requester that just lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio <= PRIO_RST;
        end else if (w_conflict) begin
            if (w_alu_grant) begin
                r_prio <= REQ_MEM;
            end else begin
                r_prio <= REQ_ALU;
            end
        end
    end

    // Writes to r0 still complete the handshake but never strobe the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rf_we <= 1'b0;
            r_rf_a3 <= '0;
            r_rf_wd <= '0;
        end else begin
            r_rf_we <= w_grant_vld && (w_grant_dest != REG_ZERO);
            if (w_grant_vld) begin
                r_rf_a3 <= w_grant_dest;
                r_rf_wd <= w_grant_data;
            end
        end
    end

    mips_cpu_wb_scoreboard u_scoreboard (
        .i_clk       (clk),
        .i_arst_n    (reset),
        .i_set_vld   (issue_valid),
        .i_set_reg   (issue_dest),
        .i_clr_vld   (w_grant_vld),
        .i_clr_reg   (w_grant_dest),
        .i_issue_vld (issue_valid),
        .i_rs        (rs),
        .i_rt        (rt),
        .o_pending   (pending),
        .o_hazard    (hazard)
    );

    assign alu_ready    = w_alu_grant;
    assign mem_ready    = w_mem_grant;
    assign rf_write_en  = r_rf_we;
    assign rf_a3        = r_rf_a3;
    assign rf_writedata = r_rf_wd;

endmodule

// File: doc/mips_cpu_reg_wb_arbiter.md
MIPS_CPU_REG_WB_ARBITER -- requirements
Module: mips_cpu_reg_wb_arbiter

Interface
REQ-001 Parameter: ALU_FIRST, default 1, selects which requester wins the first conflict after reset (1 = ALU, 0 = MEM).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 alu_valid  in  1  ALU writeback request.
REQ-005 alu_dest  in  5  ALU destination register.
REQ-006 alu_data  in  32  ALU result.
REQ-007 alu_ready  out  1  ALU request accepted this cycle.
REQ-008 mem_valid / mem_dest / mem_data / mem_ready  in/in/in/out  1/5/32/1  load-return writeback request; same meaning as the ALU signals.
REQ-009 issue_valid  in  1  decode issues an instruction that will write issue_dest.
REQ-010 issue_dest  in  5  register reserved by that issue.
REQ-011 rs, rt  in  5 each  source registers of the instruction in decode.
REQ-012 rf_write_en  out  1  register-file write strobe.
REQ-013 rf_a3  out  5  register-file write address.
REQ-014 rf_writedata  out  32  register-file write data.
REQ-015 pending  out  32  scoreboard; bit n = register n awaits writeback.
REQ-016 hazard  out  1  combinational; high when issue_valid and pending[rs] or pending[rt].

Function
REQ-017 A handshake completes on a requester when valid and ready are both high at a rising edge.
REQ-018 The block accepts at most one request per cycle; no backpressure from the register file.
REQ-019 Only one valid: that requester's ready is high in the same cycle (combinational from the valids and the priority pointer).
REQ-020 Both valid: the requester favoured by the priority pointer gets ready; the other's ready is low.
REQ-021 The priority pointer flips to favour the loser only after a conflict cycle; a non-conflict grant does not change it.
REQ-022 Requesters hold valid, dest and data stable until their handshake completes.
REQ-023 An accepted request drives rf_write_en=1, rf_a3=dest and rf_writedata=data for exactly the next cycle (1-cycle registered latency).
REQ-024 rf_write_en is 0 in any cycle following a cycle with no handshake.
REQ-025 A request with dest=0 completes its handshake and keeps rf_write_en at 0.
REQ-026 issue_valid with issue_dest!=0 sets pending[issue_dest] at the edge.
REQ-027 An accepted request clears pending[dest] at the same edge as the handshake.
REQ-028 If a set and a clear target the same register at the same edge, the set wins.
REQ-029 pending[0] is constantly 0.
REQ-030 hazard ignores rs/rt equal to 0 and reflects pending before the current edge; there is no forwarding.

Reset
REQ-031 Asserting reset immediately clears pending to 0 and drives rf_write_en=0, rf_a3=0 and rf_writedata=0.
REQ-032 Asserting reset immediately sets the priority pointer per ALU_FIRST.
REQ-033 Reset mid-transfer drops the in-flight write; no write strobe is produced after reset deasserts unless a new handshake completes.
REQ-034 The ready outputs follow the valids combinationally during reset, but no handshake takes effect while reset is asserted.

Structure
REQ-035 Shared package mips_cpu_pkg holds: REG_W=5, DATA_W=32, REG_ZERO=5'd0, and a requester enum {REQ_ALU, REQ_MEM} used for the priority pointer.
REQ-036 The scoreboard (pending register, set/clear logic, hazard lookup) is one sub-module: mips_cpu_wb_scoreboard.

Verification
REQ-037 alu_valid=1, dest=5, data=0xDEADBEEF, mem idle -> alu_ready=1 the same cycle; next cycle rf_write_en=1, rf_a3=5, rf_writedata=0xDEADBEEF.
REQ-038 Both valid for 4 consecutive cycles with ALU_FIRST=1 -> grants alternate ALU, MEM, ALU, MEM; each held request is written exactly once.
REQ-039 mem_valid with dest=0, data=0x1234 -> mem_ready=1, rf_write_en stays 0, pending unchanged.
REQ-040 issue dest=8 and later rs=8 -> pending[8]=1, hazard=1; after ALU writeback to 8, pending[8]=0 and hazard=0; same-edge issue to 8 plus writeback to 8 -> pending[8] stays 1.
REQ-041 Assert reset in the cycle after a handshake -> rf_write_en=0 and pending=0 immediately; after release, the pointer favours ALU.
